// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Cycles per RAM access, accept edge to next possible accept edge.
    localparam int unsigned PHASE_COUNT = 4;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake and RAM-side strobe bundle for ram_arbiter.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_addr, ram_data_in, ram_cs, ram_we, ram_oe,
        input  ram_data_out
    );

    // Requesters plus attached RAM
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_addr, ram_data_in, ram_cs, ram_we, ram_oe,
        output ram_data_out
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone request wins; on a tie the requester
// that did not win last time is granted.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one asynchronous single-port RAM between two requesters, sequencing
// every access through setup / strobe / hold phases with registered strobes.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    state_e                state;
    logic                  last_grant;
    logic                  owner;
    logic                  is_write;
    logic [1:0]            grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter_2 u_rr (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .enable     (state == IDLE),
        .grant      (grant)
    );

    // Ready is the grant itself, so a request is accepted whenever it is granted.
    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign sel_we    = grant[1] ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            is_write        <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_data_in <= '0;
            bus.ram_cs      <= 1'b0;
            bus.ram_we      <= 1'b0;
            bus.ram_oe      <= 1'b0;
            bus.rsp0_valid  <= 1'b0;
            bus.rsp1_valid  <= 1'b0;
            bus.rsp0_rdata  <= '0;
            bus.rsp1_rdata  <= '0;
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner           <= grant[1];
                        last_grant      <= grant[1];
                        is_write        <= sel_we;
                        bus.ram_addr    <= sel_addr;
                        bus.ram_data_in <= sel_wdata;
                        bus.ram_cs      <= 1'b1;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    bus.ram_we <= is_write;
                    bus.ram_oe <= ~is_write;
                    state      <= STROBE;
                end
                STROBE: begin
                    // Read data is taken while oe is still asserted.
                    bus.ram_we <= 1'b0;
                    bus.ram_oe <= 1'b0;
                    if (!is_write) begin
                        if (owner) bus.rsp1_rdata <= bus.ram_data_out;
                        else       bus.rsp0_rdata <= bus.ram_data_out;
                    end
                    if (owner) bus.rsp1_valid <= 1'b1;
                    else       bus.rsp0_valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    bus.ram_cs <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, arbitration and
// reset corner sequences, and randomized traffic against a transaction-level model.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached asynchronous RAM
    logic [DW-1:0] ram [256];
    always @(posedge clk) if (bus.ram_cs && bus.ram_we) ram[bus.ram_addr] <= bus.ram_data_in;
    assign bus.ram_data_out = (bus.ram_cs && bus.ram_oe) ? ram[bus.ram_addr] : '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester drive state
    bit            d_v   [2];
    bit            d_we  [2];
    logic [AW-1:0] d_addr[2];
    logic [DW-1:0] d_wd  [2];

    // Transaction-level reference model
    logic [DW-1:0] mmem  [256];
    bit            m_last;
    int            free_at;
    bit            pend  [2];
    int            rsp_at[2];
    bit            rwe   [2];
    logic [DW-1:0] rdat  [2];
    logic [DW-1:0] hold  [2];
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd;
    bit            cur_we;

    // Observations of the DUT
    bit            prev_cs;
    logic [AW-1:0] saved_addr;
    int            dacc[2];
    int            drsp[2];
    int            rcnt[2];
    int            g_who[$];
    int            g_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0;
            hold[k] = '0;
            d_v[k]  = 1'b0;
        end
        m_last  = 1'b1;
        free_at = cyc;
        prev_cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("rst_cs_immediate", 32'(bus.ram_cs), 32'd0);
        chk("rst_we_immediate", 32'(bus.ram_we), 32'd0);
        chk("rst_oe_immediate", 32'(bus.ram_oe), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        end
        chk("rst_ram_addr",    32'(bus.ram_addr),    32'd0);
        chk("rst_ram_data_in", 32'(bus.ram_data_in), 32'd0);
        chk("rst_rsp0_rdata",  32'(bus.rsp0_rdata),  32'd0);
        chk("rst_rsp1_rdata",  32'(bus.rsp1_rdata),  32'd0);
        chk("rst_ready0",      32'(bus.req0_ready),  32'd0);
        chk("rst_ready1",      32'(bus.req1_ready),  32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance.
    task automatic tick();
        bit e [2];
        bit ev, dv, phase_cs, strobe;
        logic [DW-1:0] dr;
        int n;
        bus.req0_valid = d_v[0]; bus.req0_we = d_we[0];
        bus.req0_addr  = d_addr[0]; bus.req0_wdata = d_wd[0];
        bus.req1_valid = d_v[1]; bus.req1_we = d_we[1];
        bus.req1_addr  = d_addr[1]; bus.req1_wdata = d_wd[1];
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = pend[k] && (rsp_at[k] == cyc);
            if (ev) begin
                if (!rwe[k]) hold[k] = rdat[k];
                pend[k] = 1'b0;
            end
            dv = (k == 1) ? bus.rsp1_valid : bus.rsp0_valid;
            dr = (k == 1) ? bus.rsp1_rdata : bus.rsp0_rdata;
            if (dv) begin
                drsp[k] = cyc;
                rcnt[k]++;
            end
            chk((k == 1) ? "rsp1_valid" : "rsp0_valid", 32'(dv), 32'(ev));
            chk((k == 1) ? "rsp1_rdata" : "rsp0_rdata", 32'(dr), 32'(hold[k]));
        end

        // RAM phase position follows from the cycles elapsed since the last accept.
        phase_cs = (cyc < free_at) && (cyc + 3 >= free_at);
        strobe   = phase_cs && (cyc + 2 == free_at);
        chk("ram_cs", 32'(bus.ram_cs), 32'(phase_cs));
        chk("ram_we", 32'(bus.ram_we), 32'(strobe && cur_we));
        chk("ram_oe", 32'(bus.ram_oe), 32'(strobe && !cur_we));
        chk("we_oe_exclusive", 32'(bus.ram_we & bus.ram_oe), 32'd0);
        if (bus.ram_we || bus.ram_oe) chk("strobe_without_cs", 32'(bus.ram_cs), 32'd1);
        if (bus.ram_cs && prev_cs) chk("ram_addr_stable", 32'(bus.ram_addr), 32'(saved_addr));
        if (bus.ram_cs && !prev_cs) saved_addr = bus.ram_addr;
        prev_cs = bus.ram_cs;
        if (phase_cs) begin
            chk("ram_addr", 32'(bus.ram_addr), 32'(cur_addr));
            if (cur_we) chk("ram_data_in", 32'(bus.ram_data_in), 32'(cur_wd));
        end

        e[0] = 1'b0;
        e[1] = 1'b0;
        if (cyc >= free_at) begin
            if (d_v[0] && d_v[1]) begin
                e[0] = m_last;
                e[1] = !m_last;
            end else begin
                e[0] = d_v[0];
                e[1] = d_v[1];
            end
        end
        chk("req0_ready", 32'(bus.req0_ready), 32'(e[0]));
        chk("req1_ready", 32'(bus.req1_ready), 32'(e[1]));
        if (bus.req0_ready && d_v[0]) begin dacc[0] = cyc; g_who.push_back(0); g_cyc.push_back(cyc); end
        if (bus.req1_ready && d_v[1]) begin dacc[1] = cyc; g_who.push_back(1); g_cyc.push_back(cyc); end

        if (e[0] || e[1]) begin
            n = e[1] ? 1 : 0;
            cur_addr = d_addr[n];
            cur_we   = d_we[n];
            cur_wd   = d_wd[n];
            if (d_we[n]) mmem[d_addr[n]] = d_wd[n];
            else         rdat[n] = mmem[d_addr[n]];
            rwe[n]    = d_we[n];
            pend[n]   = 1'b1;
            rsp_at[n] = cyc + 3;
            free_at   = cyc + int'(PHASE_COUNT);
            m_last    = (n == 1);
            d_v[n]    = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        bit            who;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vt [8];
    int   exp_who [4];
    int   rc0;

    initial begin
        vt[0] = '{who: 1'b0, we: 1'b1, addr: 8'h10, wdata: 8'hA5, exp_rdata: 8'h00};
        vt[1] = '{who: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
        vt[2] = '{who: 1'b0, we: 1'b1, addr: 8'hFF, wdata: 8'hFF, exp_rdata: 8'h00};
        vt[3] = '{who: 1'b0, we: 1'b1, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h00};
        vt[4] = '{who: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hFF};
        vt[5] = '{who: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h00};
        vt[6] = '{who: 1'b1, we: 1'b1, addr: 8'h33, wdata: 8'h5C, exp_rdata: 8'h00};
        vt[7] = '{who: 1'b1, we: 1'b0, addr: 8'h33, wdata: 8'h00, exp_rdata: 8'h5C};
        exp_who = '{0, 1, 0, 1};

        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'(i ^ 8'h3C);
            mmem[i] = 8'(i ^ 8'h3C);
        end
        for (int k = 0; k < 2; k++) begin
            d_v[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wd[k] = '0;
            dacc[k] = 0; drsp[k] = 0; rcnt[k] = 0;
        end
        cur_addr = '0; cur_wd = '0; cur_we = 1'b0; saved_addr = '0;
        bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

        do_reset();
        repeat (2) tick();

        // Directed vectors, one access at a time
        for (int i = 0; i < 8; i++) begin
            int w;
            w = vt[i].who ? 1 : 0;
            rc0 = rcnt[w];
            d_v[w] = 1'b1; d_we[w] = vt[i].we; d_addr[w] = vt[i].addr; d_wd[w] = vt[i].wdata;
            repeat (5) tick();
            chk("vec_rsp_count", 32'(rcnt[w] - rc0), 32'd1);
            chk("vec_latency", 32'(drsp[w] - dacc[w]), 32'd3);
            if (!vt[i].we) chk("vec_rdata", 32'(w ? bus.rsp1_rdata : bus.rsp0_rdata), 32'(vt[i].exp_rdata));
        end

        // Both requesters continuously valid: grants must alternate starting with req0
        do_reset();
        g_who.delete();
        g_cyc.delete();
        d_we[0] = 1'b0; d_addr[0] = 8'h01;
        d_we[1] = 1'b0; d_addr[1] = 8'h02;
        for (int i = 0; i < 17; i++) begin
            d_v[0] = 1'b1;
            d_v[1] = 1'b1;
            tick();
        end
        d_v[0] = 1'b0; d_v[1] = 1'b0;
        repeat (4) tick();
        chk("rr_grant_count_ok", 32'(g_who.size() >= 4), 32'd1);
        if (g_who.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_grant_order", 32'(g_who[i]), 32'(exp_who[i]));
                if (i > 0) chk("rr_accept_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(PHASE_COUNT));
            end
        end

        // Reset during STROBE of a req1 write aborts it without a response
        rc0 = rcnt[1];
        d_v[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 8'h20; d_wd[1] = 8'h77;
        tick();
        tick();
        chk("strobe_we_before_reset", 32'(bus.ram_we), 32'd1);
        do_reset();
        repeat (4) tick();
        chk("abort_no_rsp1", 32'(rcnt[1] - rc0), 32'd0);
        d_v[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h11;
        tick();
        chk("idle_after_abort", 32'(d_v[1]), 32'd0);
        repeat (4) tick();

        // Randomized traffic against the model; 0x20 was left undefined by the abort
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!d_v[k] && ($urandom_range(0, 2) == 0)) begin
                    d_v[k]    = 1'b1;
                    d_we[k]   = 1'($urandom_range(0, 1));
                    d_addr[k] = 8'($urandom);
                    if (d_addr[k] == 8'h20) d_addr[k] = 8'h21;
                    d_wd[k]   = 8'($urandom);
                end
            end
            tick();
        end
        d_v[0] = 1'b0; d_v[1] = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
